vram_arbiter: RTL and testbench

- Shares the single-port VRAM between two requesters: the background/sprite render fetch path and the CPU PPUDATA path (reads/writes relayed from the PPU register interface).
- Renderer has priority. The CPU request is held in a one-entry pending buffer and granted in any cycle the renderer leaves free.
- A starvation counter forces a CPU slot if the renderer monopolises VRAM.
- Sits between ppu_render / ppu_reg and VRAM inside the PPU top level.

---
 rtl/vram_arbiter_if.sv | 66 ++++++
 rtl/vram_arbiter.sv | 125 ++++++++++++
 tb/tb_vram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: renderer read port, CPU PPUDATA port, VRAM port.
// slave = arbiter side; master = requesters and VRAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              ren_req;
  logic [ADDR_W-1:0] ren_addr;
  logic              ren_ack;
  logic              ren_rvalid;
  logic [DATA_W-1:0] ren_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              cpu_drop;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] VRAM_addr;
  logic              VRAM_WE;
  logic [DATA_W-1:0] VRAM_data_in;
  logic [DATA_W-1:0] VRAM_data_out;

  modport slave (
    input  ren_req,
    input  ren_addr,
    output ren_ack,
    output ren_rvalid,
    output ren_rdata,
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_busy,
    output cpu_drop,
    output cpu_rvalid,
    output cpu_rdata,
    output VRAM_addr,
    output VRAM_WE,
    output VRAM_data_in,
    input  VRAM_data_out
  );

  modport master (
    output ren_req,
    output ren_addr,
    input  ren_ack,
    input  ren_rvalid,
    input  ren_rdata,
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_busy,
    input  cpu_drop,
    input  cpu_rvalid,
    input  cpu_rdata,
    input  VRAM_addr,
    input  VRAM_WE,
    input  VRAM_data_in,
    output VRAM_data_out
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: renderer first, CPU via one-entry pending buffer.
// Ports: VGA_CLK, reset (async, active-high), bus (vram_arbiter_if.slave).
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            VGA_CLK,
  input  logic            reset,
  vram_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_REN  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;

  logic              r_pend_valid;
  logic              r_pend_we;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_wdata;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [1:0]        r_ret_owner;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_drop;

  logic              w_starved;
  logic              w_cpu_gnt;
  logic              w_ren_gnt;
  logic              w_pend_load;
  logic              w_drop;
  logic [1:0]        w_ret_next;
  logic              w_ren_ret;
  logic              w_cpu_ret;

  assign w_starved = (r_starve_cnt == CNT_MAX);

  // A starved pending request steals the slot even while the
  // renderer is asking; the renderer holds its request until acked.
  assign w_cpu_gnt = ~reset & r_pend_valid &
                     (~bus.ren_req | w_starved);
  assign w_ren_gnt = ~reset & bus.ren_req & ~w_cpu_gnt;

  // Reloading in the grant cycle keeps back-to-back CPU accesses
  // bubble-free.
  assign w_pend_load = bus.cpu_req &
                       (~r_pend_valid | w_cpu_gnt);
  assign w_drop      = bus.cpu_req & r_pend_valid & ~w_cpu_gnt;

  always_comb begin
    w_ret_next = OWN_NONE;
    unique case (1'b1)
      w_cpu_gnt: w_ret_next = r_pend_we ? OWN_NONE : OWN_CPU;
      w_ren_gnt: w_ret_next = OWN_REN;
      default:   w_ret_next = OWN_NONE;
    endcase
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
    end else if (w_pend_load) begin
      r_pend_valid <= 1'b1;
      r_pend_we    <= bus.cpu_we;
      r_pend_addr  <= bus.cpu_addr;
      r_pend_wdata <= bus.cpu_wdata;
    end else if (w_cpu_gnt) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (~r_pend_valid | w_cpu_gnt) begin
      r_starve_cnt <= '0;
    end else if (~w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_ret_owner <= OWN_NONE;
      r_cpu_drop  <= 1'b0;
    end else begin
      r_ret_owner <= w_ret_next;
      r_cpu_drop  <= w_drop;
    end
  end

  assign w_ren_ret = (r_ret_owner == OWN_REN);
  assign w_cpu_ret = (r_ret_owner == OWN_CPU);

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_cpu_rdata <= '0;
    end else if (w_cpu_ret) begin
      r_cpu_rdata <= bus.VRAM_data_out;
    end
  end

  assign bus.VRAM_addr    = w_cpu_gnt ? r_pend_addr
                                      : bus.ren_addr;
  assign bus.VRAM_WE      = w_cpu_gnt & r_pend_we;
  assign bus.VRAM_data_in = r_pend_wdata;

  assign bus.ren_ack    = w_ren_gnt;
  assign bus.ren_rvalid = w_ren_ret;
  assign bus.ren_rdata  = reset ? '0 : bus.VRAM_data_out;

  // Bypass so the returning read is visible in its rvalid cycle;
  // the hold register keeps it afterwards.
  assign bus.cpu_rvalid = w_cpu_ret;
  assign bus.cpu_rdata  = w_cpu_ret ? bus.VRAM_data_out
                                    : r_cpu_rdata;
  assign bus.cpu_busy   = r_pend_valid;
  assign bus.cpu_drop   = r_cpu_drop;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus
// randomized traffic against a queue/arithmetic reference model.
module tb_vram_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  vram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .VGA_CLK(clk),
    .reset(rst),
    .bus(bus)
  );

  logic [DW-1:0] mem [0:65535];
  logic          pre_en   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.VRAM_WE) mem[bus.VRAM_addr] <= bus.VRAM_data_in;
    bus.VRAM_data_out <= mem[bus.VRAM_addr];
  end

  task automatic next;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    bus.ren_req   = 1'b0;
    bus.ren_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    next();
    pre_en = 1'b0;
  endtask

  task automatic test_reset;
    idle_in();
    preload(16'h2000, 8'h11);
    preload(16'h2001, 8'h22);
    preload(16'h2002, 8'h33);
    preload(16'h23C0, 8'h00);
    preload(16'h0100, 8'h00);
    preload(16'h0200, 8'hEE);
    preload(16'h0201, 8'hEE);
    preload(16'h0300, 8'h00);
    preload(16'h0301, 8'h00);
    for (int i = 0; i < 64; i++) preload(AW'(i), DW'($urandom));
    bus.ren_req = 1'b1; bus.ren_addr = 16'h1234;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.ren_ack !== 1'b0) $display("FAIL rst_ack got %0b want 0", bus.ren_ack); else n_pass++;
    n_chk++; if (bus.VRAM_WE !== 1'b0) $display("FAIL rst_we got %0b want 0", bus.VRAM_WE); else n_pass++;
    n_chk++; if (bus.ren_rvalid !== 1'b0) $display("FAIL rst_rrv got %0b want 0", bus.ren_rvalid); else n_pass++;
    n_chk++; if (bus.ren_rdata !== 8'h00) $display("FAIL rst_rrd got %0h want 0", bus.ren_rdata); else n_pass++;
    n_chk++; if (bus.cpu_busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", bus.cpu_busy); else n_pass++;
    n_chk++; if (bus.cpu_drop !== 1'b0) $display("FAIL rst_drop got %0b want 0", bus.cpu_drop); else n_pass++;
    n_chk++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL rst_crv got %0b want 0", bus.cpu_rvalid); else n_pass++;
    n_chk++; if (bus.cpu_rdata !== 8'h00) $display("FAIL rst_crd got %0h want 0", bus.cpu_rdata); else n_pass++;
    n_chk++; if (bus.VRAM_addr !== 16'h1234) $display("FAIL rst_addr got %0h want 1234", bus.VRAM_addr); else n_pass++;
    n_chk++; if (bus.VRAM_data_in !== 8'h00) $display("FAIL rst_din got %0h want 0", bus.VRAM_data_in); else n_pass++;
    next();
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    n_chk++; if (bus.cpu_busy !== 1'b0) $display("FAIL rel_busy got %0b want 0", bus.cpu_busy); else n_pass++;
    next();
  endtask

  task automatic test_renderer;
    logic [DW-1:0] d [0:2];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    for (int i = 0; i < 5; i++) begin
      bus.ren_req  = (i < 3);
      bus.ren_addr = 16'h2000 + AW'(i);
      @(negedge clk);
      n_chk++; if (bus.ren_ack !== (i < 3)) $display("FAIL ren_ack c%0d got %0b want %0b", i, bus.ren_ack, (i < 3)); else n_pass++;
      n_chk++; if (bus.ren_rvalid !== (i >= 1 && i <= 3)) $display("FAIL ren_rv c%0d got %0b", i, bus.ren_rvalid); else n_pass++;
      if (i >= 1 && i <= 3) begin
        n_chk++; if (bus.ren_rdata !== d[i-1]) $display("FAIL ren_rd c%0d got %0h want %0h", i, bus.ren_rdata, d[i-1]); else n_pass++;
      end
      next();
    end
    idle_in();
  endtask

  task automatic test_cpu_wr_rd;
    for (int c = 0; c < 7; c++) begin
      bus.cpu_req   = (c == 0 || c == 2);
      bus.cpu_we    = (c == 0);
      bus.cpu_addr  = 16'h23C0;
      bus.cpu_wdata = 8'hA5;
      @(negedge clk);
      n_chk++; if (bus.VRAM_WE !== (c == 1)) $display("FAIL cw_we c%0d got %0b want %0b", c, bus.VRAM_WE, (c == 1)); else n_pass++;
      n_chk++; if (bus.cpu_busy !== (c == 1 || c == 3)) $display("FAIL cw_busy c%0d got %0b", c, bus.cpu_busy); else n_pass++;
      n_chk++; if (bus.cpu_rvalid !== (c == 4)) $display("FAIL cw_rv c%0d got %0b want %0b", c, bus.cpu_rvalid, (c == 4)); else n_pass++;
      if (c == 1 || c == 3) begin
        n_chk++; if (bus.VRAM_addr !== 16'h23C0) $display("FAIL cw_addr c%0d got %0h want 23c0", c, bus.VRAM_addr); else n_pass++;
      end
      if (c >= 4) begin
        n_chk++; if (bus.cpu_rdata !== 8'hA5) $display("FAIL cw_rd c%0d got %0h want a5", c, bus.cpu_rdata); else n_pass++;
      end
      next();
    end
    idle_in();
  endtask

  task automatic test_starvation;
    int g;
    g = 1 + LIM;
    bus.ren_req  = 1'b1;
    bus.ren_addr = 16'h2001;
    for (int c = 0; c < 9; c++) begin
      bus.cpu_req   = (c == 0);
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 16'h0100;
      bus.cpu_wdata = 8'h5A;
      @(negedge clk);
      n_chk++; if (bus.ren_ack !== (c != g)) $display("FAIL st_ack c%0d got %0b want %0b", c, bus.ren_ack, (c != g)); else n_pass++;
      n_chk++; if (bus.VRAM_WE !== (c == g)) $display("FAIL st_we c%0d got %0b want %0b", c, bus.VRAM_WE, (c == g)); else n_pass++;
      n_chk++; if (bus.cpu_busy !== (c >= 1 && c <= g)) $display("FAIL st_busy c%0d got %0b", c, bus.cpu_busy); else n_pass++;
      if (c == g) begin
        n_chk++; if (bus.VRAM_addr !== 16'h0100) $display("FAIL st_addr got %0h want 0100", bus.VRAM_addr); else n_pass++;
      end
      next();
    end
    idle_in();
    n_chk++; if (mem[16'h0100] !== 8'h5A) $display("FAIL st_mem got %0h want 5a", mem[16'h0100]); else n_pass++;
  endtask

  task automatic test_overflow;
    int g;
    g = 1 + LIM;
    bus.ren_req  = 1'b1;
    bus.ren_addr = 16'h2002;
    for (int c = 0; c < 9; c++) begin
      bus.cpu_req   = (c == 0 || c == 1);
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = (c == 0) ? 16'h0200 : 16'h0201;
      bus.cpu_wdata = (c == 0) ? 8'h01 : 8'h02;
      @(negedge clk);
      n_chk++; if (bus.cpu_drop !== (c == 2)) $display("FAIL ov_drop c%0d got %0b want %0b", c, bus.cpu_drop, (c == 2)); else n_pass++;
      n_chk++; if (bus.VRAM_WE !== (c == g)) $display("FAIL ov_we c%0d got %0b want %0b", c, bus.VRAM_WE, (c == g)); else n_pass++;
      next();
    end
    idle_in();
    n_chk++; if (mem[16'h0200] !== 8'h01) $display("FAIL ov_mem0 got %0h want 01", mem[16'h0200]); else n_pass++;
    n_chk++; if (mem[16'h0201] !== 8'hEE) $display("FAIL ov_mem1 got %0h want ee", mem[16'h0201]); else n_pass++;
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 5; c++) begin
      bus.cpu_req   = (c == 0 || c == 1);
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = (c == 0) ? 16'h0300 : 16'h0301;
      bus.cpu_wdata = (c == 0) ? 8'h77 : 8'h88;
      @(negedge clk);
      n_chk++; if (bus.cpu_drop !== 1'b0) $display("FAIL bb_drop c%0d got %0b want 0", c, bus.cpu_drop); else n_pass++;
      n_chk++; if (bus.cpu_busy !== (c == 1 || c == 2)) $display("FAIL bb_busy c%0d got %0b", c, bus.cpu_busy); else n_pass++;
      n_chk++; if (bus.VRAM_WE !== (c == 1 || c == 2)) $display("FAIL bb_we c%0d got %0b", c, bus.VRAM_WE); else n_pass++;
      if (c == 1 || c == 2) begin
        n_chk++; if (bus.VRAM_addr !== ((c == 1) ? 16'h0300 : 16'h0301)) $display("FAIL bb_addr c%0d got %0h", c, bus.VRAM_addr); else n_pass++;
      end
      next();
    end
    idle_in();
    n_chk++; if (mem[16'h0300] !== 8'h77) $display("FAIL bb_mem0 got %0h want 77", mem[16'h0300]); else n_pass++;
    n_chk++; if (mem[16'h0301] !== 8'h88) $display("FAIL bb_mem1 got %0h want 88", mem[16'h0301]); else n_pass++;
  endtask

  task automatic test_reset_mid_read;
    bus.ren_req = 1'b1; bus.ren_addr = 16'h2000;
    @(negedge clk);
    n_chk++; if (bus.ren_ack !== 1'b1) $display("FAIL rm_ack0 got %0b want 1", bus.ren_ack); else n_pass++;
    next();
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.ren_rvalid !== 1'b0) $display("FAIL rm_rv got %0b want 0", bus.ren_rvalid); else n_pass++;
    n_chk++; if (bus.ren_ack !== 1'b0) $display("FAIL rm_ack got %0b want 0", bus.ren_ack); else n_pass++;
    n_chk++; if (bus.ren_rdata !== 8'h00) $display("FAIL rm_rd got %0h want 0", bus.ren_rdata); else n_pass++;
    n_chk++; if (bus.VRAM_WE !== 1'b0) $display("FAIL rm_we got %0b want 0", bus.VRAM_WE); else n_pass++;
    n_chk++; if (bus.cpu_busy !== 1'b0) $display("FAIL rm_busy got %0b want 0", bus.cpu_busy); else n_pass++;
    n_chk++; if (bus.cpu_rdata !== 8'h00) $display("FAIL rm_crd got %0h want 0", bus.cpu_rdata); else n_pass++;
    n_chk++; if (bus.VRAM_data_in !== 8'h00) $display("FAIL rm_din got %0h want 0", bus.VRAM_data_in); else n_pass++;
    n_chk++; if (bus.VRAM_addr !== 16'h2000) $display("FAIL rm_addr got %0h want 2000", bus.VRAM_addr); else n_pass++;
    next();
    next();
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    n_chk++; if (bus.ren_rvalid !== 1'b0) $display("FAIL rm_rv1 got %0b want 0", bus.ren_rvalid); else n_pass++;
    n_chk++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL rm_crv1 got %0b want 0", bus.cpu_rvalid); else n_pass++;
    next();
    bus.ren_req = 1'b1; bus.ren_addr = 16'h2001;
    @(negedge clk);
    n_chk++; if (bus.ren_ack !== 1'b1) $display("FAIL rm_ack2 got %0b want 1", bus.ren_ack); else n_pass++;
    next();
    idle_in();
    @(negedge clk);
    n_chk++; if (bus.ren_rvalid !== 1'b1) $display("FAIL rm_rv2 got %0b want 1", bus.ren_rvalid); else n_pass++;
    n_chk++; if (bus.ren_rdata !== 8'h22) $display("FAIL rm_rd2 got %0h want 22", bus.ren_rdata); else n_pass++;
    next();
  endtask

  task automatic test_random;
    logic [DW-1:0] shadow [0:63];
    bit            m_pend, m_we, m_drop, m_hreq, wins, e_ack, e_we;
    logic [AW-1:0] m_addr, m_haddr, e_addr;
    logic [DW-1:0] m_wd, m_rdat, m_hold, e_crd;
    int            m_since, m_ret, cyc;
    rst = 1'b1;
    idle_in();
    next();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) shadow[i] = mem[i];
    m_pend = 0; m_we = 0; m_drop = 0; m_hreq = 0;
    m_addr = '0; m_haddr = '0; m_wd = '0; m_rdat = '0; m_hold = '0;
    m_since = 0; m_ret = 0;
    for (cyc = 0; cyc < 1500; cyc++) begin
      if (m_hreq) begin
        bus.ren_req = 1'b1; bus.ren_addr = m_haddr;
      end else begin
        bus.ren_req  = ($urandom_range(0, 9) < 6);
        bus.ren_addr = AW'($urandom_range(0, 63));
      end
      bus.cpu_req   = ($urandom_range(0, 9) < 3);
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = AW'($urandom_range(0, 63));
      bus.cpu_wdata = DW'($urandom);
      @(negedge clk);
      wins   = m_pend && (!bus.ren_req || (cyc - m_since) >= LIM);
      e_ack  = bus.ren_req && !wins;
      e_we   = wins && m_we;
      e_addr = wins ? m_addr : bus.ren_addr;
      e_crd  = (m_ret == 2) ? m_rdat : m_hold;
      n_chk++; if (bus.ren_ack !== e_ack) $display("FAIL rnd_ack @%0d got %0b want %0b", cyc, bus.ren_ack, e_ack); else n_pass++;
      n_chk++; if (bus.VRAM_WE !== e_we) $display("FAIL rnd_we @%0d got %0b want %0b", cyc, bus.VRAM_WE, e_we); else n_pass++;
      n_chk++; if (bus.VRAM_addr !== e_addr) $display("FAIL rnd_addr @%0d got %0h want %0h", cyc, bus.VRAM_addr, e_addr); else n_pass++;
      if (e_we) begin
        n_chk++; if (bus.VRAM_data_in !== m_wd) $display("FAIL rnd_din @%0d got %0h want %0h", cyc, bus.VRAM_data_in, m_wd); else n_pass++;
      end
      n_chk++; if (bus.ren_rvalid !== (m_ret == 1)) $display("FAIL rnd_rrv @%0d got %0b", cyc, bus.ren_rvalid); else n_pass++;
      if (m_ret == 1) begin
        n_chk++; if (bus.ren_rdata !== m_rdat) $display("FAIL rnd_rrd @%0d got %0h want %0h", cyc, bus.ren_rdata, m_rdat); else n_pass++;
      end
      n_chk++; if (bus.cpu_rvalid !== (m_ret == 2)) $display("FAIL rnd_crv @%0d got %0b", cyc, bus.cpu_rvalid); else n_pass++;
      n_chk++; if (bus.cpu_rdata !== e_crd) $display("FAIL rnd_crd @%0d got %0h want %0h", cyc, bus.cpu_rdata, e_crd); else n_pass++;
      n_chk++; if (bus.cpu_busy !== m_pend) $display("FAIL rnd_busy @%0d got %0b want %0b", cyc, bus.cpu_busy, m_pend); else n_pass++;
      n_chk++; if (bus.cpu_drop !== m_drop) $display("FAIL rnd_drop @%0d got %0b want %0b", cyc, bus.cpu_drop, m_drop); else n_pass++;
      if (m_ret == 2) m_hold = m_rdat;
      m_ret = 0;
      if (wins) begin
        if (m_we) shadow[m_addr[5:0]] = m_wd;
        else begin m_ret = 2; m_rdat = shadow[m_addr[5:0]]; end
      end else if (bus.ren_req) begin
        m_ret = 1; m_rdat = shadow[bus.ren_addr[5:0]];
      end
      m_drop = bus.cpu_req && m_pend && !wins;
      if (bus.cpu_req && (!m_pend || wins)) begin
        m_pend = 1; m_we = bus.cpu_we; m_addr = bus.cpu_addr;
        m_wd = bus.cpu_wdata; m_since = cyc + 1;
      end else if (wins) begin
        m_pend = 0;
      end
      m_hreq  = bus.ren_req && !e_ack;
      m_haddr = bus.ren_addr;
      next();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_renderer();
    test_cpu_wr_rd();
    test_starvation();
    test_overflow();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
